// File: rtl/uart_source_arbiter_pkg.sv
// Shared definitions for the UART source arbiter: FSM encoding, default
// payload/timeout sizing and small helpers.
package uart_source_arbiter_pkg;

  localparam int NUM_SOURCES_DEF    = 4;
  localparam int PAYLOAD_W_DEF      = 272;
  localparam int TIMEOUT_CYCLES_DEF = 1200000;  // 100 ms at 12 MHz
  localparam int SRC_ID_W           = 3;
  localparam int TMR_W              = 24;
  localparam int TOCNT_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  function automatic logic [TOCNT_W-1:0] sat_inc(input logic [TOCNT_W-1:0] v);
    return (v == {TOCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_source_arbiter_rr_select.sv
// Combinational round-robin selector: first requester after last_grant wins,
// wrapping modulo NUM_SOURCES.
module rr_select
  import uart_source_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_SOURCES_DEF
) (
  input  logic [NUM_SOURCES-1:0] i_req,
  input  logic [SRC_ID_W-1:0]    i_last_grant,
  output logic [SRC_ID_W-1:0]    o_grant,
  output logic                   o_valid
);

  localparam int IW = $clog2(NUM_SOURCES);

  int w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      w_idx = (int'(i_last_grant) + i) % NUM_SOURCES;
      if (!o_valid && i_req[w_idx[IW-1:0]]) begin
        o_valid = 1'b1;
        o_grant = SRC_ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_source_arbiter.sv
// Shares one serial_transmitter between NUM_SOURCES frame producers: sync the
// ready levels, grant round-robin, hold the frame until ack or timeout.
module uart_source_arbiter
  import uart_source_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES    = NUM_SOURCES_DEF,
  parameter int PAYLOAD_W      = PAYLOAD_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                             clk_12MHz,
  input  logic                             rst_n,
  input  logic [NUM_SOURCES-1:0]           data_avl_in,
  input  logic [NUM_SOURCES*PAYLOAD_W-1:0] sensor_iterations_in,
  output logic [NUM_SOURCES-1:0]           reset_parser_out,
  output logic                             data_avl,
  output logic [PAYLOAD_W-1:0]             sensor_iterations,
  output logic [SRC_ID_W-1:0]              source_id,
  input  logic                             reset_parser,
  output logic [TOCNT_W-1:0]               timeout_count
);

  localparam int IW = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]                r_sync1, r_sync2;
  arb_state_e                            r_state, w_state_nxt;
  logic [SRC_ID_W-1:0]                   r_last_grant, r_winner;
  logic [TMR_W-1:0]                      r_timer;
  logic [TOCNT_W-1:0]                    r_timeout_cnt;
  logic [PAYLOAD_W-1:0]                  r_payload;
  logic [SRC_ID_W-1:0]                   r_source_id;
  logic [NUM_SOURCES-1:0][PAYLOAD_W-1:0] w_payload_arr;
  logic [SRC_ID_W-1:0]                   w_rr_grant;
  logic                                  w_rr_valid;
  logic                                  w_ack_timeout;
  logic                                  w_winner_idle;

  assign w_payload_arr = sensor_iterations_in;
  assign w_ack_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  // Release completes only once the source has withdrawn and the transmitter has let go.
  assign w_winner_idle = !r_sync2[r_winner[IW-1:0]] && !reset_parser;

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= data_avl_in;
      r_sync2 <= r_sync1;
    end
  end

  rr_select #(.NUM_SOURCES(NUM_SOURCES)) u_rr_select (
    .i_req        (r_sync2),
    .i_last_grant (r_last_grant),
    .o_grant      (w_rr_grant),
    .o_valid      (w_rr_valid)
  );

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_rr_valid) w_state_nxt = ST_LOAD;
      ST_LOAD:     w_state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (reset_parser || w_ack_timeout) w_state_nxt = ST_RELEASE;
      ST_RELEASE:  if (w_winner_idle) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant  <= SRC_ID_W'(NUM_SOURCES - 1);
      r_winner      <= '0;
      r_timer       <= '0;
      r_timeout_cnt <= '0;
      r_payload     <= '0;
      r_source_id   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rr_valid) r_winner <= w_rr_grant;
        end
        ST_LOAD: begin
          r_payload   <= w_payload_arr[r_winner[IW-1:0]];
          r_source_id <= r_winner;
          r_timer     <= '0;
        end
        ST_WAIT_ACK: begin
          r_timer <= r_timer + 1'b1;
          // A same-cycle ack wins over the timeout.
          if (!reset_parser && w_ack_timeout) r_timeout_cnt <= sat_inc(r_timeout_cnt);
        end
        ST_RELEASE: begin
          if (w_winner_idle) r_last_grant <= r_winner;
        end
        default: ;
      endcase
    end
  end

  // Handshake levels decode straight from state so reset clears them at once.
  always_comb begin
    reset_parser_out = '0;
    for (int k = 0; k < NUM_SOURCES; k++)
      reset_parser_out[k] = (r_state == ST_RELEASE) && (r_winner == SRC_ID_W'(k));
  end

  assign data_avl          = (r_state == ST_WAIT_ACK);
  assign sensor_iterations = r_payload;
  assign source_id         = r_source_id;
  assign timeout_count     = r_timeout_cnt;

endmodule

// File: doc/uart_source_arbiter.md
UART_SOURCE_ARBITER -- requirements
Module: uart_source_arbiter

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 4, giving the number of octo_manager sources sharing one serial_transmitter (range 2..8).
REQ-002 SHALL have parameter PAYLOAD_W, default 272, giving the sensor_iterations width per source.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1200000, giving the transmitter-acknowledge timeout (100 ms at 12 MHz).
REQ-004 SHALL use one clock and an asynchronous active-low reset; the ports are named clk_12MHz and rst_n.
REQ-005 clk_12MHz  in  1  UART-domain clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 data_avl_in  in  NUM_SOURCES  per-source frame-ready level from the 96 MHz domain.
REQ-008 sensor_iterations_in  in  NUM_SOURCES*PAYLOAD_W  flattened payloads; source k occupies bits [k*PAYLOAD_W +: PAYLOAD_W].
REQ-009 reset_parser_out  out  NUM_SOURCES  per-source frame-consumed level.
REQ-010 data_avl  out  1  frame-ready level to serial_transmitter.
REQ-011 sensor_iterations  out  PAYLOAD_W  registered payload to serial_transmitter.
REQ-012 source_id  out  3  index of the granted source.
REQ-013 reset_parser  in  1  frame-consumed indication from serial_transmitter.
REQ-014 timeout_count  out  8  saturating count of acknowledge timeouts.

Function
REQ-015 SHALL pass each data_avl_in bit through a 2-flop synchronizer; all decisions use the synchronized value (avl_s).
REQ-016 SHALL implement states IDLE, LOAD, WAIT_ACK, RELEASE.
REQ-017 IDLE: if any avl_s bit is set, SHALL select a winner round-robin, starting from (last_grant+1) mod NUM_SOURCES, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 LOAD: SHALL register the winner's payload into sensor_iterations and its index into source_id, and go to WAIT_ACK; data_avl SHALL assert in the first WAIT_ACK cycle.
REQ-019 WAIT_ACK: SHALL hold data_avl=1 with payload and source_id stable; on reset_parser=1 it SHALL go to RELEASE.
REQ-020 WAIT_ACK timeout: if TIMEOUT_CYCLES elapse without reset_parser, SHALL increment timeout_count (saturating at 255) and go to RELEASE.
REQ-021 RELEASE: SHALL drive data_avl=0 and reset_parser_out[winner]=1; once avl_s[winner]=0 and reset_parser=0, SHALL deassert reset_parser_out[winner], update last_grant to the winner, and return to IDLE.
REQ-022 SHALL assert at most one reset_parser_out bit at any time; non-granted bits SHALL be 0.
REQ-023 A source deasserting data_avl_in during WAIT_ACK SHALL NOT abort the frame; the frame completes normally.
REQ-024 Requests arriving while a grant is active SHALL be held pending and served in round-robin order; a continuously requesting source SHALL wait at most NUM_SOURCES-1 frames.
REQ-025 The timeout counter SHALL be 24 bits; it SHALL clear on entry to WAIT_ACK and SHALL NOT run in any other state.

Reset
REQ-026 On rst_n=0, SHALL immediately force: state=IDLE, data_avl=0, reset_parser_out=0, sensor_iterations=0, source_id=0, timeout_count=0, last_grant=NUM_SOURCES-1, synchronizers=0.
REQ-027 Reset in any state SHALL abandon the frame without any reset_parser_out pulse; after release, arbitration restarts at source 0.

Structure
REQ-028 SHALL place the state encoding, PAYLOAD_W default and TIMEOUT_CYCLES default in the shared receivers package.
REQ-029 SHALL instantiate the round-robin priority selector as sub-module rr_select (inputs: request vector, last_grant; outputs: grant index, valid); the selector is combinational.

Verification
REQ-030 Single source: avl_in=4'b0001 -> source_id=0, data_avl=1 after 2 sync + 1 LOAD cycles; reset_parser pulse -> reset_parser_out=4'b0001 until avl_in[0] drops.
REQ-031 All four sources continuously requesting, transmitter acks each after 10 cycles -> grant order 0,1,2,3,0; no source is starved.
REQ-032 Transmitter never acks with TIMEOUT_CYCLES=50 -> data_avl drops after 50 WAIT_ACK cycles; timeout_count=1; arbitration proceeds to the next source.
REQ-033 rst_n low mid-WAIT_ACK -> all outputs 0 asynchronously; after release, a request from source 2 is granted with source_id=2.
REQ-034 Source 1 drops avl_in during WAIT_ACK -> payload is held, frame completes on ack, and reset_parser_out[1] pulses.
REQ-035 256 consecutive timeouts -> timeout_count saturates at 255.
